// File: rtl/ppcm_defs.sv
// Shared definitions for the parallel PCM controller: device command codes,
// status register bit positions and the controller FSM state encoding.
package ppcm_defs;

   localparam logic [7:0] CMD_PROGRAM    = 8'h40;
   localparam logic [7:0] CMD_CLR_STATUS = 8'h50;
   localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

   localparam int SR_READY   = 7;
   localparam int SR_PGM_ERR = 4;
   localparam int SR_LOCK    = 1;

   typedef enum logic [3:0] {
      ST_INIT,    // holding the device in reset
      ST_IDLE,    // waiting for a Wishbone request
      ST_RD,      // array read, one bus cycle per beat
      ST_PSEL,    // pick the next selected beat to program
      ST_WCMD,    // write the program command
      ST_WDAT,    // write the beat's data
      ST_POLL,    // read status until ready or poll budget spent
      ST_CLR,     // clear status after an error
      ST_RDARR,   // return the device to read-array mode
      ST_ACK,
      ST_ERR
   } state_t;

endpackage

// File: rtl/ppcm_bus_cycle.sv
// Executes one timed device bus cycle. A read holds ce_n/oe_n low for T_RD
// cycles; a write holds ce_n low and drives data for 2*T_WP cycles, with we_n
// low for the first T_WP. All pins are registered. o_done is high during the
// last cycle, and a new i_start in that cycle chains the next bus cycle
// without a gap.
module ppcm_bus_cycle #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 16,
   parameter int T_RD      = 12,
   parameter int T_WP      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_write,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_done,
   output logic                 o_ce_n,
   output logic                 o_oe_n,
   output logic                 o_we_n,
   output logic [ADDR_BITS-1:0] o_addr,
   output logic [DATA_BITS-1:0] o_dout,
   output logic                 o_dout_en
);

   localparam int CNT_MAX = (T_RD > 2 * T_WP) ? T_RD : 2 * T_WP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic          r_active;
   logic          r_write;
   logic [CW-1:0] r_cnt;

   assign o_done = r_active && (r_cnt == '0);

   // Cycle counter and pin drivers; a start always wins over the end of the
   // current cycle so back-to-back beats keep the strobes asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every flop here is a control or pin register, so all of them
         // take the reset; sequential state always uses non-blocking <=.
         r_active  <= 1'b0;
         r_write   <= 1'b0;
         r_cnt     <= '0;
         o_ce_n    <= 1'b1;
         o_oe_n    <= 1'b1;
         o_we_n    <= 1'b1;
         o_addr    <= '0;
         o_dout    <= '0;
         o_dout_en <= 1'b0;
      end else if (i_start) begin
         r_active  <= 1'b1;
         r_write   <= i_write;
         r_cnt     <= i_write ? CW'(2 * T_WP - 1) : CW'(T_RD - 1);
         o_addr    <= i_addr;
         o_dout    <= i_data;
         o_ce_n    <= 1'b0;
         o_oe_n    <= i_write;
         o_we_n    <= !i_write;
         o_dout_en <= i_write;
      end else if (r_active) begin
         if (r_cnt == '0) begin
            r_active  <= 1'b0;
            o_ce_n    <= 1'b1;
            o_oe_n    <= 1'b1;
            o_we_n    <= 1'b1;
            o_dout_en <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_write && r_cnt == CW'(T_WP))
               o_we_n <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_ppcm_rw.sv
// Wishbone classic slave front end for a parallel PCM device: 32-bit array
// reads split into DATA_BITS beats, and word programming with status polling,
// error clear and return to read-array mode for every selected beat.
module wb_ppcm_rw
   import ppcm_defs::*;
#(
   parameter int                    ADDR_BITS = 24,
   parameter logic [31-ADDR_BITS:0] HIGH_ADDR = 8'hFF,
   parameter int                    DATA_BITS = 16,
   parameter int                    T_RST     = 20,
   parameter int                    T_RD      = 12,
   parameter int                    T_WP      = 6,
   parameter int                    POLL_MAX  = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 pcm_busy,
   output logic                 pcm_ce_n,
   output logic                 pcm_rst_n,
   output logic                 pcm_oe_n,
   output logic                 pcm_we_n,
   output logic [ADDR_BITS-1:0] pcm_addr,
   input  logic [DATA_BITS-1:0] pcm_din,
   output logic [DATA_BITS-1:0] pcm_dout,
   output logic                 pcm_dout_en,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [29:0]          wbs_addr_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_data_i,
   output logic [31:0]          wbs_data_o,
   output logic                 wbs_ack_o,
   output logic                 wbs_err_o
);

   localparam int BEATS = 32 / DATA_BITS;
   localparam int BPB   = DATA_BITS / 8;
   localparam int RST_W = $clog2(T_RST + 1);
   localparam int PW    = $clog2(POLL_MAX + 1);

   state_t                 r_state, w_next;
   logic [RST_W-1:0]       r_rst_cnt;
   logic [ADDR_BITS-3:0]   r_waddr;
   logic [3:0]             r_sel;
   logic [31:0]            r_data;
   logic [2:0]             r_beat;
   logic                   r_issued;
   logic                   r_err;
   logic [PW-1:0]          r_poll;

   logic                   w_req;
   logic [31-ADDR_BITS:0]  w_hi;
   logic                   w_partial;
   logic [3:0]             w_grp;
   logic                   w_beat_sel;
   logic [DATA_BITS-1:0]   w_beat_data;
   logic [2:0]             w_addr_beat;
   logic [1:0]             w_off;
   logic                   w_start;
   logic                   w_write;
   logic [DATA_BITS-1:0]   w_bc_data;
   logic                   w_done;

   assign w_req       = wbs_cyc_i && wbs_stb_i;
   assign w_hi        = wbs_addr_i[29 -: (32 - ADDR_BITS)];
   assign w_grp       = r_sel >> (32'(r_beat) * BPB);
   assign w_beat_sel  = |w_grp[BPB-1:0];
   assign w_beat_data = DATA_BITS'(r_data >> (32'(r_beat) * DATA_BITS));
   // A read chains the next beat in the done cycle, so the address must
   // already point one beat ahead of the beat being captured.
   assign w_addr_beat = (r_state == ST_RD && r_issued) ? r_beat + 3'd1 : r_beat;
   assign w_off       = 2'(32'(w_addr_beat) * BPB);

   assign pcm_busy  = (r_state != ST_IDLE);
   assign wbs_ack_o = (r_state == ST_ACK) && wbs_cyc_i;
   assign wbs_err_o = (r_state == ST_ERR) && wbs_cyc_i;

   // Flag a write whose byte selects cover only part of a device beat.
   always_comb begin
      w_partial = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         if (wbs_sel_i[b*BPB +: BPB] != '0 && wbs_sel_i[b*BPB +: BPB] != '1)
            w_partial = 1'b1;
      end
   end

   // Next-state and bus-cycle request decode.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal
      // unassigned and infers a latch.
      w_next    = r_state;
      w_start   = 1'b0;
      w_write   = 1'b0;
      w_bc_data = '0;
      unique case (r_state)
         ST_INIT: begin
            if (r_rst_cnt == RST_W'(T_RST - 1))
               w_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_req) begin
               if (w_hi != HIGH_ADDR)        w_next = ST_ERR;
               else if (!wbs_we_i)           w_next = ST_RD;
               else if (w_partial)           w_next = ST_ERR;
               else if (wbs_sel_i == 4'b0)   w_next = ST_ACK;
               else                          w_next = ST_PSEL;
            end
         end
         ST_RD: begin
            w_start = !r_issued || (w_done && r_beat != 3'(BEATS - 1));
            if (w_done && r_beat == 3'(BEATS - 1))
               w_next = ST_ACK;
         end
         ST_PSEL: begin
            if (r_err)                       w_next = ST_ERR;
            else if (r_beat == 3'(BEATS))    w_next = ST_ACK;
            else if (w_beat_sel)             w_next = ST_WCMD;
         end
         ST_WCMD: begin
            w_start   = !r_issued;
            w_write   = 1'b1;
            w_bc_data = DATA_BITS'(CMD_PROGRAM);
            if (w_done) w_next = ST_WDAT;
         end
         ST_WDAT: begin
            w_start   = !r_issued;
            w_write   = 1'b1;
            w_bc_data = w_beat_data;
            if (w_done) w_next = ST_POLL;
         end
         ST_POLL: begin
            w_start = !r_issued;
            if (w_done) begin
               if (pcm_din[SR_READY])
                  w_next = (pcm_din[SR_PGM_ERR] || pcm_din[SR_LOCK]) ? ST_CLR : ST_RDARR;
               else if (r_poll == PW'(POLL_MAX - 1))
                  w_next = ST_CLR;
            end
         end
         ST_CLR: begin
            w_start   = !r_issued;
            w_write   = 1'b1;
            w_bc_data = DATA_BITS'(CMD_CLR_STATUS);
            if (w_done) w_next = ST_RDARR;
         end
         ST_RDARR: begin
            w_start   = !r_issued;
            w_write   = 1'b1;
            w_bc_data = DATA_BITS'(CMD_READ_ARRAY);
            if (w_done) w_next = ST_PSEL;
         end
         ST_ACK, ST_ERR: w_next = ST_IDLE;
         default:        w_next = ST_INIT;
      endcase
   end

   // State register, request latch, beat/poll counters and read data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_rst_cnt  <= '0;
         pcm_rst_n  <= 1'b0;
         r_waddr    <= '0;
         r_sel      <= '0;
         r_data     <= '0;
         r_beat     <= '0;
         r_issued   <= 1'b0;
         r_err      <= 1'b0;
         r_poll     <= '0;
         wbs_data_o <= '0;
      end else begin
         r_state  <= w_next;
         r_issued <= w_done ? w_start : (r_issued | w_start);
         if (w_next == ST_CLR)
            r_err <= 1'b1;
         unique case (r_state)
            ST_INIT: begin
               r_rst_cnt <= r_rst_cnt + RST_W'(1);
               if (w_next == ST_IDLE)
                  pcm_rst_n <= 1'b1;
            end
            ST_IDLE: begin
               if (w_req) begin
                  r_waddr <= wbs_addr_i[ADDR_BITS-3:0];
                  r_sel   <= wbs_sel_i;
                  r_data  <= wbs_data_i;
                  r_beat  <= '0;
                  r_err   <= 1'b0;
                  r_poll  <= '0;
               end
            end
            ST_RD: begin
               if (w_done) begin
                  wbs_data_o[32'(r_beat) * DATA_BITS +: DATA_BITS] <= pcm_din;
                  r_beat <= r_beat + 3'd1;
               end
            end
            ST_PSEL: begin
               if (w_next == ST_PSEL)
                  r_beat <= r_beat + 3'd1;
            end
            ST_POLL: begin
               if (w_done)
                  r_poll <= r_poll + PW'(1);
            end
            ST_RDARR: begin
               if (w_done) begin
                  r_beat <= r_beat + 3'd1;
                  r_poll <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   ppcm_bus_cycle #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .T_RD      (T_RD),
      .T_WP      (T_WP)
   ) u_bus (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_write   (w_write),
      .i_addr    ({r_waddr, w_off}),
      .i_data    (w_bc_data),
      .o_done    (w_done),
      .o_ce_n    (pcm_ce_n),
      .o_oe_n    (pcm_oe_n),
      .o_we_n    (pcm_we_n),
      .o_addr    (pcm_addr),
      .o_dout    (pcm_dout),
      .o_dout_en (pcm_dout_en)
   );

endmodule

// File: tb/tb_wb_ppcm_rw.sv
// Directed bench for wb_ppcm_rw with a small behavioural PCM device model.
module tb_wb_ppcm_rw;

   localparam int ADDR_BITS = 24;
   localparam int DATA_BITS = 16;
   localparam int T_RST     = 20;
   localparam int T_RD      = 12;
   localparam int T_WP      = 6;
   localparam int POLL_MAX  = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 pcm_busy, pcm_ce_n, pcm_rst_n, pcm_oe_n, pcm_we_n;
   logic [ADDR_BITS-1:0] pcm_addr;
   logic [DATA_BITS-1:0] pcm_din;
   logic [DATA_BITS-1:0] pcm_dout;
   logic                 pcm_dout_en;
   logic                 wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [29:0]          wbs_addr_i;
   logic [3:0]           wbs_sel_i;
   logic [31:0]          wbs_data_i;
   logic [31:0]          wbs_data_o;
   logic                 wbs_ack_o, wbs_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   // device model state
   logic                 status_mode = 1'b0;
   logic [DATA_BITS-1:0] dev_status  = '0;
   logic [ADDR_BITS-1:0] log_addr[$];
   logic [DATA_BITS-1:0] log_data[$];
   int                   n_polls   = 0;
   int                   n_overlap = 0;
   int                   n_acks    = 0;
   logic                 ce_seen   = 1'b0;
   logic                 prev_oe   = 1'b1;
   logic                 prev_we   = 1'b1;

   wb_ppcm_rw #(
      .ADDR_BITS (ADDR_BITS),
      .HIGH_ADDR (8'hFF),
      .DATA_BITS (DATA_BITS),
      .T_RST     (T_RST),
      .T_RD      (T_RD),
      .T_WP      (T_WP),
      .POLL_MAX  (POLL_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pcm_busy    (pcm_busy),
      .pcm_ce_n    (pcm_ce_n),
      .pcm_rst_n   (pcm_rst_n),
      .pcm_oe_n    (pcm_oe_n),
      .pcm_we_n    (pcm_we_n),
      .pcm_addr    (pcm_addr),
      .pcm_din     (pcm_din),
      .pcm_dout    (pcm_dout),
      .pcm_dout_en (pcm_dout_en),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_addr_i  (wbs_addr_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_data_i  (wbs_data_i),
      .wbs_data_o  (wbs_data_o),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_err_o   (wbs_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [23:0] a);
      if (a == 24'h000010)      return 16'h1234;
      else if (a == 24'h000012) return 16'hABCD;
      else                      return {8'h5A, a[7:0]};
   endfunction

   assign pcm_din = status_mode ? dev_status : mem_word(pcm_addr);

   // Device-side monitor: logs completed write cycles, counts read strobes,
   // tracks mode changes and illegal strobe combinations.
   always @(negedge clk) begin
      if (!pcm_oe_n && !pcm_we_n)    n_overlap++;
      if (pcm_dout_en && !pcm_oe_n)  n_overlap++;
      if (!pcm_ce_n)                 ce_seen = 1'b1;
      if (wbs_ack_o)                 n_acks++;
      if (prev_oe && !pcm_oe_n)      n_polls++;
      if (!prev_we && pcm_we_n) begin
         log_addr.push_back(pcm_addr);
         log_data.push_back(pcm_dout);
         status_mode = (pcm_dout != 16'h00FF);
      end
      prev_oe = pcm_oe_n;
      prev_we = pcm_we_n;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_mon();
      log_addr.delete();
      log_data.delete();
      n_polls = 0;
      n_acks  = 0;
      ce_seen = 1'b0;
   endtask

   task automatic check_log(input string tag, input int n, input logic [15:0] exp [6]);
      check({tag, "_len"}, 64'(log_data.size()), 64'(n));
      for (int i = 0; i < n; i++)
         check(tag, (i < log_data.size()) ? 64'(log_data[i]) : 64'hDEAD_0000_0000, 64'(exp[i]));
   endtask

   // One Wishbone transfer; lat counts cycles from the stb cycle to ack/err.
   task automatic wb_xfer(input logic we, input logic [31:0] baddr, input logic [3:0] sel,
                          input logic [31:0] wdata, output int lat, output logic ack,
                          output logic err, output logic [31:0] rdata);
      @(posedge clk); #1;
      wbs_cyc_i  = 1'b1;
      wbs_stb_i  = 1'b1;
      wbs_we_i   = we;
      wbs_addr_i = baddr[31:2];
      wbs_sel_i  = sel;
      wbs_data_i = wdata;
      lat = -1; ack = 1'b0; err = 1'b0; rdata = '0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (wbs_ack_o || wbs_err_o) begin
            lat = i; ack = wbs_ack_o; err = wbs_err_o; rdata = wbs_data_o;
            break;
         end
      end
      @(posedge clk); #1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wait_dev_rst(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (pcm_rst_n) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, n;
      logic        ack, err, found;
      logic [31:0] rd;
      logic [15:0] exp6 [6];

      rst = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_addr_i = '0; wbs_sel_i = '0; wbs_data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_pcm_rst_n", pcm_rst_n, 0);
      check("rst_busy", pcm_busy, 1);
      check("rst_strobes", {pcm_ce_n, pcm_oe_n, pcm_we_n}, 3'b111);
      check("rst_dout", {pcm_dout_en, pcm_dout}, 17'h0);
      check("rst_ack_err", {wbs_ack_o, wbs_err_o}, 2'b00);
      check("rst_data_o", wbs_data_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_dev_rst(n);
      check("init_rst_cycles", n, T_RST);

      // array read, both beats, with exact latency
      clear_mon();
      wb_xfer(1'b0, 32'hFF000010, 4'hF, 32'h0, lat, ack, err, rd);
      check("rd_data", rd, 32'hABCD1234);
      check("rd_lat", lat, 2 * T_RD + 2);
      check("rd_ack_err", {ack, err}, 2'b10);

      // top of the address window
      wb_xfer(1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, lat, ack, err, rd);
      check("rd_top_data", rd, 32'h5AFE5AFC);

      // full word program, device reports ready with no errors
      dev_status = 16'h0080;
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'hF, 32'hDEADBEEF, lat, ack, err, rd);
      check("wr_ack_err", {ack, err}, 2'b10);
      exp6 = '{16'h0040, 16'hBEEF, 16'h00FF, 16'h0040, 16'hDEAD, 16'h00FF};
      check_log("wr_log", 6, exp6);
      check("wr_addr_lo", (log_addr.size() > 1) ? 64'(log_addr[1]) : 64'hFFFF_FFFF, 64'h10);
      check("wr_addr_hi", (log_addr.size() > 4) ? 64'(log_addr[4]) : 64'hFFFF_FFFF, 64'h12);
      check("wr_polls", n_polls, 2);

      // only the upper beat selected
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'b1100, 32'h55660000, lat, ack, err, rd);
      check("wr_hi_ack_err", {ack, err}, 2'b10);
      exp6 = '{16'h0040, 16'h5566, 16'h00FF, 16'h0, 16'h0, 16'h0};
      check_log("wr_hi_log", 3, exp6);
      check("wr_hi_addr", (log_addr.size() > 1) ? 64'(log_addr[1]) : 64'hFFFF_FFFF, 64'h12);

      // partial lane write is rejected without touching the device
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'b0001, 32'h11223344, lat, ack, err, rd);
      check("part_ack_err", {ack, err}, 2'b01);
      check("part_lat", lat, 1);
      check("part_no_ce", ce_seen, 0);

      // empty write is acknowledged without touching the device
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'b0000, 32'h11223344, lat, ack, err, rd);
      check("sel0_ack_err", {ack, err}, 2'b10);
      check("sel0_lat", lat, 1);
      check("sel0_no_ce", ce_seen, 0);

      // address outside the window
      clear_mon();
      wb_xfer(1'b0, 32'h7F000000, 4'hF, 32'h0, lat, ack, err, rd);
      check("badaddr_ack_err", {ack, err}, 2'b01);
      check("badaddr_no_ce", ce_seen, 0);

      // device never becomes ready: poll budget expires
      dev_status = 16'h0000;
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'b0011, 32'h00001111, lat, ack, err, rd);
      check("tmo_ack_err", {ack, err}, 2'b01);
      check("tmo_polls", n_polls, POLL_MAX);
      exp6 = '{16'h0040, 16'h1111, 16'h0050, 16'h00FF, 16'h0, 16'h0};
      check_log("tmo_log", 4, exp6);

      // program error reported: remaining beat is abandoned
      dev_status = 16'h0090;
      clear_mon();
      wb_xfer(1'b1, 32'hFF000010, 4'hF, 32'hCAFEF00D, lat, ack, err, rd);
      check("perr_ack_err", {ack, err}, 2'b01);
      check("perr_polls", n_polls, 1);
      exp6 = '{16'h0040, 16'hF00D, 16'h0050, 16'h00FF, 16'h0, 16'h0};
      check_log("perr_log", 4, exp6);

      // cycle withdrawn mid-read: sequence completes, no ack
      dev_status = 16'h0080;
      clear_mon();
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_addr_i = 30'h3FC00004; wbs_sel_i = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!pcm_busy) begin
            found = 1'b1;
            break;
         end
      end
      check("drop_idle", found, 1);
      check("drop_no_ack", n_acks, 0);

      // reset during the data write cycle
      clear_mon();
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_addr_i = 30'h3FC00004; wbs_sel_i = 4'hF; wbs_data_i = 32'hDEADBEEF;
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!pcm_we_n && pcm_dout == 16'hBEEF) begin
            found = 1'b1;
            break;
         end
      end
      check("mid_wdat_reached", found, 1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_strobes", {pcm_ce_n, pcm_oe_n, pcm_we_n}, 3'b111);
      check("mid_rst_dout", {pcm_dout_en, pcm_dout}, 17'h0);
      check("mid_rst_dev", {pcm_rst_n, pcm_busy}, 2'b01);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_dev_rst(n);
      check("mid_rst_cycles", n, T_RST);
      status_mode = 1'b0;
      wb_xfer(1'b0, 32'hFF000010, 4'hF, 32'h0, lat, ack, err, rd);
      check("post_rst_rd", rd, 32'hABCD1234);
      check("post_rst_ack", {ack, err}, 2'b10);

      check("no_strobe_overlap", n_overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_ppcm_rw.md
Name: wb_ppcm_rw

Overview:
- Parallel PCM controller with a Wishbone classic slave port on a single clock domain.
- Supports 32-bit array reads and word programming (program-command sequence with status polling).
- Parametrised for an 8- or 16-bit device data bus and for timing in clock cycles.
- Sits on the system Wishbone bus as the non-volatile memory slave, replacing the read-only PCM device.

Parameters:
ADDR_BITS, 24, device byte-address width; wbs_addr_i[31:ADDR_BITS] must equal HIGH_ADDR
HIGH_ADDR, 8'hFF, required value of the upper Wishbone address bits (width 32-ADDR_BITS)
DATA_BITS, 16, device bus width, 8 or 16; BEATS = 32/DATA_BITS
T_RST, 20, cycles pcm_rst_n held low after reset release
T_RD, 12, cycles from address/oe_n valid to data capture
T_WP, 6, cycles pcm_we_n low per write cycle; same count we_n high afterwards
POLL_MAX, 50000, status polls before timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pcm_busy  out  1  high whenever the FSM is not IDLE
pcm_ce_n  out  1  chip enable, active low
pcm_rst_n  out  1  device reset, active low
pcm_oe_n  out  1  output enable, active low
pcm_we_n  out  1  write enable, active low
pcm_addr  out  ADDR_BITS  device byte address; bit0 forced 0 when DATA_BITS=16
pcm_din  in  DATA_BITS  data from device
pcm_dout  out  DATA_BITS  data to device
pcm_dout_en  out  1  tristate enable for pcm_dout
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone controls
wbs_addr_i  in  30  word address [31:2]
wbs_sel_i  in  4  byte selects
wbs_data_i  in  32  write data
wbs_data_o  out  32  read data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_err_o  out  1  single-cycle error

Behaviour:
- Reset (async, active-high): state INIT; all *_n outputs high except pcm_rst_n=0; pcm_dout_en=0; pcm_dout=0; wbs_ack_o=wbs_err_o=0; wbs_data_o=0; pcm_busy=1.
- INIT: count T_RST cycles, then pcm_rst_n=1 -> IDLE.
- IDLE: on cyc&stb, latch address/sel/data/we.
  - Upper address != HIGH_ADDR -> ERR.
  - Write with any selected lane group partial (DATA_BITS=16: sel[1:0] or sel[3:2] equal to 01/10) -> ERR.
  - Write with sel=0 -> ACK (no device access).
  - Otherwise -> RD or PGM.
- RD: for beat b = 0..BEATS-1: pcm_addr = {word_addr, b*DATA_BITS/8}, ce_n=oe_n=0, wait T_RD cycles, capture pcm_din into wbs_data_o[b*DATA_BITS +: DATA_BITS] (little-endian). Then ce_n=oe_n=1 -> ACK.
- PGM, repeated per selected beat only:
  - WCMD: write cycle, data 0x40. Write cycle = ce_n=0, dout_en=1, we_n=0 for T_WP cycles, then we_n=1 for T_WP cycles.
  - WDAT: write cycle with the beat's data.
  - POLL: read cycle (T_RD); if pcm_din[7]=1, check bits[4]|[1]; else repeat; count polls.
  - Status error bits set -> CLR (write 0x50); set error flag.
  - Poll count reaches POLL_MAX -> CLR; set error flag.
  - Afterwards, or on success, write 0xFF (read-array) before the next beat or exit.
  - Exit -> ACK, or ERR if the error flag is set.
- ACK/ERR: assert wbs_ack_o or wbs_err_o for exactly one cycle -> IDLE. The bus must drop stb before the next request; a stb still high in the IDLE cycle after ACK/ERR is a new request.
- Read latency: 1 + BEATS*T_RD + 1 cycles from stb to ack.
- pcm_dout_en is high only in write cycles; oe_n and we_n are never low together.
- Request dropped (cyc=0) mid-operation: the device sequence still completes; ack/err is suppressed if cyc=0 in that cycle.
- Reset mid-PGM: return immediately to INIT; pcm_rst_n pulse aborts the device operation.

Decomposition:
- Shared package ppcm_defs holds:
  - command constants CMD_PROGRAM=0x40, CMD_CLR_STATUS=0x50, CMD_READ_ARRAY=0xFF;
  - status bit indices SR_READY=7, SR_PGM_ERR=4, SR_LOCK=1;
  - the FSM state encoding.
- One sub-module, ppcm_bus_cycle: executes one timed read or write cycle (start/done handshake, T_RD/T_WP counter) and drives the pins. The top FSM sequences these cycles.

Test Plan:
- Read, DATA_BITS=16: stb at 0xFF000010, device returns 0x1234 at byte 0x10 and 0xABCD at 0x12 -> wbs_data_o=0xABCD1234; ack exactly 1+2*T_RD+1 cycles after stb.
- Write 0xDEADBEEF, sel=1111 -> device sees 0x40, 0xBEEF at 0x10, polls, then 0x40, 0xDEAD at 0x12, polls, each followed by 0xFF; status 0x80 returned -> ack, no err.
- Write with sel=0001 (DATA_BITS=16) -> err in cycle 2, no device strobes.
- Address 0x7F000000 -> err, pcm_ce_n stays high.
- Model keeps status 0x00 -> after POLL_MAX polls, write 0x50 then 0xFF, then err. Model returns 0x90 -> same path, err after first status read.
- rst asserted during WDAT -> outputs at reset values same cycle, pcm_rst_n low T_RST cycles, then a following read succeeds.
